// File: rtl/alu_pkg.sv
// Opcode map, flag bit positions and opcode legality shared by the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_AND   = 2;
    localparam int unsigned OP_OR    = 3;
    localparam int unsigned OP_XOR   = 4;
    localparam int unsigned OP_SHL   = 5;
    localparam int unsigned OP_SHR   = 6;
    localparam int unsigned OP_ASR   = 7;
    localparam int unsigned OP_ADC   = 8;
    localparam int unsigned OP_SBC   = 9;
    localparam int unsigned OP_PASSB = 10;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    function automatic logic is_legal_op(input int unsigned op);
        return (op <= OP_PASSB);
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Combinational ALU core: one operation on A/B with carry-in, producing result,
// {V,C,N,Z} flags and an illegal-opcode indication.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic [OPW-1:0]   op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o,
    output logic             illegal_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic             arith;
    logic             c_flag;
    int unsigned      op_u;

    always_comb begin
        op_u      = 32'(op_i);
        arith     = 1'b0;
        b_eff     = b_i;
        cin       = 1'b0;
        c_flag    = 1'b0;
        result_o  = '0;
        illegal_o = !is_legal_op(op_u);

        case (op_u)
            OP_ADD: arith = 1'b1;
            OP_SUB: begin
                arith = 1'b1;
                b_eff = ~b_i;
                cin   = 1'b1;
            end
            OP_ADC: begin
                arith = 1'b1;
                cin   = carry_i;
            end
            OP_SBC: begin
                arith = 1'b1;
                b_eff = ~b_i;
                cin   = carry_i;
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SHL: begin
                result_o = {a_i[WIDTH-2:0], 1'b0};
                c_flag   = a_i[WIDTH-1];
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[WIDTH-1:1]};
                c_flag   = a_i[0];
            end
            OP_ASR: begin
                result_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
                c_flag   = a_i[0];
            end
            OP_PASSB: result_o = b_i;
            default: ;
        endcase

        // Subtraction is folded into the adder as A + ~B + cin, so C=1 means no borrow.
        sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            result_o = sum[WIDTH-1:0];
            c_flag   = sum[WIDTH];
        end

        flags_o = '0;
        if (!illegal_o) begin
            flags_o[FLG_Z] = (result_o == '0);
            flags_o[FLG_N] = result_o[WIDTH-1];
            flags_o[FLG_C] = c_flag;
            flags_o[FLG_V] = arith & (a_i[WIDTH-1] == b_eff[WIDTH-1])
                                   & (result_o[WIDTH-1] != a_i[WIDTH-1]);
        end
    end

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage valid/ready ALU pipeline: S1 holds the accepted operation, S2 holds the
// computed result and flags; accumulator and carry advance with each legal S2 load.
module alu_pipe_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_illegal,
    output logic [WIDTH-1:0] acc_value
);

    logic             s1_valid_q, s1_valid_d;
    logic [OPW-1:0]   s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_use_acc_q;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q;
    logic [3:0]       s2_flags_q;
    logic             s2_illegal_q;

    logic [WIDTH-1:0] acc_q;
    logic             carry_q;

    logic             s1_accept;
    logic             s2_load;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic             core_illegal;

    assign s2_load   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready  = ~s1_valid_q | s2_load;
    assign s1_accept = in_valid & in_ready;
    // acc_q is written on the same edge the previous op leaves S1, so chaining needs no forwarding.
    assign core_a    = s1_use_acc_q ? acc_q : s1_a_q;

    alu_core_comb #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .op_i      (s1_op_q),
        .a_i       (core_a),
        .b_i       (s1_b_q),
        .carry_i   (carry_q),
        .result_o  (core_result),
        .flags_o   (core_flags),
        .illegal_o (core_illegal)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_accept) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // S1 operand capture
    always_ff @(posedge clk) begin
        if (s1_accept) begin
            s1_op_q      <= in_op;
            s1_a_q       <= in_a;
            s1_b_q       <= in_b;
            s1_use_acc_q <= in_use_acc;
        end
    end

    // S1 -> S2 transfer, accumulator and carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_flags_q   <= '0;
            s2_illegal_q <= 1'b0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                s2_result_q  <= core_result;
                s2_flags_q   <= core_flags;
                s2_illegal_q <= core_illegal;
                if (!core_illegal) begin
                    acc_q   <= core_result;
                    carry_q <= core_flags[FLG_C];
                end
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_flags   = s2_flags_q;
    assign out_illegal = s2_illegal_q;
    assign acc_value   = acc_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Bench for alu_pipe_param: directed scenarios plus randomized traffic, all outputs
// compared against an arithmetic reference model through an in-order scoreboard.
module tb_alu_pipe_param;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;
    localparam int H = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_use_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;
    logic         out_illegal;
    logic [W-1:0] acc_value;

    int n_checks = 0;
    int n_errors = 0;
    int m_acc = 0;
    int m_cy  = 0;
    bit last_acc;

    typedef struct {
        int res;
        int flg;
        int ill;
    } exp_t;
    exp_t exp_q[$];

    alu_pipe_param #(.WIDTH(W), .OPW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_use_acc  (in_use_acc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_illegal (out_illegal),
        .acc_value   (acc_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= H) ? x - (M + 1) : x;
    endfunction

    // Reference: sequential ALU semantics on plain integers, applied in acceptance order.
    task automatic model_accept(input int op, input int a_in, input int b, input int ua);
        exp_t e;
        int a, cin, u, s, res, c, v, ill;
        a   = (ua != 0) ? m_acc : a_in;
        res = 0; c = 0; v = 0; ill = 0; u = 0; s = 0;
        cin = (op == 1) ? 1 : ((op == 8 || op == 9) ? m_cy : 0);
        case (op)
            0, 8: begin u = a + b + cin;       s = sgn(a) + sgn(b) + cin;     end
            1, 9: begin u = a + (M - b) + cin; s = sgn(a) - sgn(b) - 1 + cin; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a << 1) & M;      c = (a >= H) ? 1 : 0; end
            6: begin res = a >> 1;            c = a & 1;            end
            7: begin res = (a >> 1) | (a & H); c = a & 1;           end
            10: res = b;
            default: ill = 1;
        endcase
        if (op == 0 || op == 1 || op == 8 || op == 9) begin
            res = u & M;
            c   = (u > M) ? 1 : 0;
            v   = (s < -H || s > H - 1) ? 1 : 0;
        end
        e.res = res;
        e.ill = ill;
        e.flg = ill ? 0 : (v * 8 + c * 4 + ((res >= H) ? 2 : 0) + ((res == 0) ? 1 : 0));
        exp_q.push_back(e);
        if (ill == 0) begin
            m_acc = res;
            m_cy  = c;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 0);
            end else begin
                e = exp_q[0];
                chk("sb_result", 32'(out_result), e.res);
                chk("sb_flags", 32'(out_flags), e.flg);
                chk("sb_illegal", 32'(out_illegal), e.ill);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (last_acc) model_accept(int'(in_op), int'(in_a), int'(in_b), int'(in_use_acc));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int op, input int a, input int b, input int ua);
        in_valid   = 1'b1;
        in_op      = 4'(op);
        in_a       = W'(a);
        in_b       = W'(b);
        in_use_acc = 1'(ua);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accepted", 32'(last_acc), 1);
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_use_acc = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_flags", 32'(out_flags), 0);
        chk("rst_out_illegal", 32'(out_illegal), 0);
        chk("rst_acc", 32'(acc_value), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // ADD wrap to zero, two-cycle latency
        send(0, 'hFF, 'h01, 0);
        chk("lat_not_yet", 32'(out_valid), 0);
        tick();
        chk("lat_valid", 32'(out_valid), 1);
        chk("add_ff_res", 32'(out_result), 'h00);
        chk("add_ff_flags", 32'(out_flags), 'h5);

        send(0, 'h7F, 'h01, 0);
        tick();
        chk("add_ovf_res", 32'(out_result), 'h80);
        chk("add_ovf_flags", 32'(out_flags), 'hA);
        send(1, 'h05, 'h07, 0);
        tick();
        chk("sub_res", 32'(out_result), 'hFE);
        chk("sub_flags", 32'(out_flags), 'h2);

        // Carry chain and back-to-back accumulator use
        send(0, 'hF0, 'h20, 0);
        tick();
        chk("chain_add_res", 32'(out_result), 'h10);
        chk("chain_add_flags", 32'(out_flags), 'h4);
        send(8, 'h00, 'h00, 0);
        tick();
        chk("adc_res", 32'(out_result), 'h01);
        in_valid = 1'b1; in_op = 4'd0; in_use_acc = 1'b1; in_a = '0; in_b = W'(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("chain_accept", 32'(last_acc), 1);
        end
        in_valid = 1'b0; in_use_acc = 1'b0;
        chk("chain_res2", 32'(out_result), 'h07);
        tick();
        chk("chain_res3", 32'(out_result), 'h0A);
        chk("chain_acc", 32'(acc_value), 'h0A);
        tick();

        // Backpressure: only two ops fit while the output is stalled
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (idx < 4); in_op = 4'd0; in_a = W'(16 * idx + 1); in_b = W'(idx + 1);
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = (idx < 4); in_op = 4'd0; in_a = W'(16 * idx + 1); in_b = W'(idx + 1);
            chk("bp_nogap", 32'(out_valid), 1);
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 32'(idx), 4);
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Illegal op leaves accumulator and carry alone
        send(0, 'hFF, 'h06, 0);
        tick();
        chk("pre_ill_res", 32'(out_result), 'h05);
        chk("pre_ill_flags", 32'(out_flags), 'h4);
        send(12, 'h01, 'h02, 0);
        tick();
        chk("ill_flag", 32'(out_illegal), 1);
        chk("ill_res", 32'(out_result), 0);
        chk("ill_flags", 32'(out_flags), 0);
        chk("ill_acc", 32'(acc_value), 'h05);
        send(8, 'h00, 'h00, 0);
        tick();
        chk("ill_carry_kept", 32'(out_result), 'h01);
        tick();

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(0, 'h11, 'h22, 0);
        send(2, 'h33, 'h44, 0);
        chk("full_in_ready", 32'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_acc", 32'(acc_value), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        m_acc = 0;
        m_cy  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_quiet", 32'(out_valid), 0);
        end

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_op      = 4'($urandom_range(0, 15));
            in_a       = W'($urandom);
            in_b       = W'($urandom);
            in_use_acc = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("rand_drained", 32'(exp_q.size()), 0);
        chk("rand_final_acc", 32'(acc_value), m_acc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational ALU.
- Adds a WIDTH-generic datapath, valid/ready handshakes on input and output, and a registered accumulator and flags.
- Adds carry-chained ops (ADC/SBC), signed overflow and arithmetic shift.
- Sits between the pin-level operand unpacker and the result/flag output mux of the tile.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  OPW  opcode.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_use_acc  in  1  when 1, operand A is the accumulator instead of in_a.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_flags  out  4  {V,C,N,Z} for this result.
- out_illegal  out  1  opcode was unassigned.
- acc_value  out  WIDTH  current accumulator.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0, out_illegal=0, acc=0, carry register=0, in_ready=1 on the first cycle after release.
- Two stages.
  - S1 registers op, A, B, use_acc on in_valid&in_ready.
  - S2 registers result, flags and illegal, computed combinationally from S1 at the S1→S2 transfer.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 op/cycle.
- Advance rule: S2 loads when s1_valid & (!s2_valid | out_ready). in_ready = !s1_valid | S2 loads this cycle.
- Backpressure: outputs hold stable while out_valid & !out_ready. Order is preserved, no drops, no duplicates.
- Accumulator and carry register update in the same edge a legal result loads into S2.
  - A use_acc op in S1 sees the acc value written by the immediately preceding op, so back-to-back chaining needs no bubble.
  - Illegal ops leave acc and carry unchanged.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A+~B+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL by 1.
  - 6 SHR logical by 1.
  - 7 ASR by 1.
  - 8 ADC: A+B+carry.
  - 9 SBC: A+~B+carry.
  - 10 PASSB.
  - 11–15 illegal: result 0, flags 0, out_illegal=1.
- Arithmetic is computed in WIDTH+1 bits; result = low WIDTH bits.
- Flags:
  - Z = result==0.
  - N = result[WIDTH-1].
  - C:
    - Add/sub family: carry out (SUB: C=1 means no borrow).
    - SHL: old A[WIDTH-1].
    - SHR/ASR: old A[0].
    - Logic/PASSB: 0.
  - V: signed overflow for the add/sub family, 0 otherwise.
- Reset mid-operation discards S1/S2 contents immediately. Nothing is emitted after release.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams OP_ADD…OP_PASSB.
  - Flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3.
  - Helper function is_legal_op.
- One sub-module, alu_core_comb:
  - Purely combinational, parametrised WIDTH.
  - Inputs op, A, B, carry_in.
  - Outputs result, flags, illegal.
- The pipeline, handshake and accumulator stay in alu_pipe_param.

Test Plan:
- ADD a=0xFF b=0x01, out_ready=1 → 2 cycles later result 0x00, flags Z=1 C=1 N=0 V=0.
- ADD 0x7F+0x01 → 0x80, N=1 V=1 C=0. SUB 0x05−0x07 → 0xFE, N=1 C=0 V=0.
- Chain: ADD 0xF0+0x20 (C=1), then ADC 0x00+0x00 → 0x01. Then use_acc ADD b=0x03 three times back-to-back → results 0x04, 0x07, 0x0A, acc_value=0x0A.
- Backpressure: hold out_ready=0 and offer 4 ops.
  - in_ready drops after 2 accepted.
  - out_result is stable while stalled.
  - Release out_ready → all 4 results emerge in order, no gaps.
- Illegal op 0xC with acc=0x05 → result 0, out_illegal=1, acc_value stays 0x05, carry unchanged.
- Assert rst_n=0 with S1 and S2 full → out_valid=0 and acc_value=0 without a clock edge. No output appears after release until a new op is accepted.
